// File: rtl/i2c_pkg.sv
// Shared I2C front-end definitions: default conditioner depths and the event strobe bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_pkg;

  localparam int I2C_SYNC_STAGES_DEFAULT   = 2;
  localparam int I2C_FILTER_CYCLES_DEFAULT = 3;

  // One-cycle bus events handed to the slave FSM.
  typedef struct packed {
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
  } i2c_event_t;

endpackage

// File: rtl/i2c_glitch_filter.sv
// Synchronizes one raw I2C pin and suppresses pulses shorter than FILTER_CYCLES.
// Latency: a stable pin change reaches filt SYNC_STAGES+FILTER_CYCLES edges after first sample.
// Backpressure: none; free-running every cycle.
module i2c_glitch_filter
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES   = I2C_SYNC_STAGES_DEFAULT,
  parameter int FILTER_CYCLES = I2C_FILTER_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic filt,
  output logic filt_nxt,
  output logic upd
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  // Filtered level flips once the synchronized value has disagreed for FILTER_CYCLES cycles.
  always_comb begin
    upd      = 1'b0;
    filt_nxt = filt;
    if ((sync != filt) && (cnt_q == CNT_LAST)) begin
      upd      = 1'b1;
      filt_nxt = sync;
    end
  end

  // Sync chain, disagreement counter and filtered level; idle bus (1) after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '1;
      cnt_q  <= '0;
      filt   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      filt   <= filt_nxt;
      if ((sync == filt) || upd) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_line_conditioner.sv
// Conditions raw SCL/SDA into filtered levels, SCL edge strobes, START/STOP strobes and bus_busy.
// Latency: strobes are high in the same cycle the filtered level first shows its new value.
// Backpressure: none; strobes last one cycle and must be sampled every cycle.
module i2c_line_conditioner
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES   = I2C_SYNC_STAGES_DEFAULT,
  parameter int FILTER_CYCLES = I2C_FILTER_CYCLES_DEFAULT,
  parameter int IDLE_TIMEOUT  = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_filt,
  output logic sda_filt,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy
);

  localparam int IW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

  logic       scl_nxt, scl_upd;
  logic       sda_nxt, sda_upd;
  i2c_event_t ev_q;
  logic       busy_q;
  logic [IW-1:0] idle_cnt;

  i2c_glitch_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_scl_filter (
    .clock   (clock),
    .reset   (reset),
    .pin     (scl_in),
    .filt    (scl_filt),
    .filt_nxt(scl_nxt),
    .upd     (scl_upd)
  );

  i2c_glitch_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_sda_filter (
    .clock   (clock),
    .reset   (reset),
    .pin     (sda_in),
    .filt    (sda_filt),
    .filt_nxt(sda_nxt),
    .upd     (sda_upd)
  );

  // Strobes register at the same edge the filtered levels update; an SCL change masks START/STOP.
  always_ff @(posedge clock) begin
    if (reset) begin
      ev_q <= '0;
    end else begin
      ev_q.scl_rise  <= scl_upd & scl_nxt;
      ev_q.scl_fall  <= scl_upd & ~scl_nxt;
      ev_q.start_det <= sda_upd & ~sda_nxt & scl_filt & ~scl_upd;
      ev_q.stop_det  <= sda_upd &  sda_nxt & scl_filt & ~scl_upd;
    end
  end

  // Busy follows START/STOP one cycle later; optional idle timeout drops it silently.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q   <= 1'b0;
      idle_cnt <= '0;
    end else begin
      if (ev_q.start_det) begin
        busy_q <= 1'b1;
      end else if (ev_q.stop_det) begin
        busy_q <= 1'b0;
      end
      if ((IDLE_TIMEOUT > 0) && scl_filt && sda_filt && busy_q) begin
        if (idle_cnt == IDLE_LAST) begin
          busy_q   <= 1'b0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + IW'(1);
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  assign scl_rise  = ev_q.scl_rise;
  assign scl_fall  = ev_q.scl_fall;
  assign start_det = ev_q.start_det;
  assign stop_det  = ev_q.stop_det;
  assign bus_busy  = busy_q;

endmodule

// File: doc/i2c_line_conditioner.md
Name: i2c_line_conditioner

Overview:
Front-end conditioner for the raw I2C pins. It sits between the chip pad inputs (SCL on io_in[0], SDA on io_in[1]) and the I2C slave. Each line is synchronized to clock and glitch-filtered. The block then emits single-cycle SCL edge strobes and START/STOP strobes, plus a bus-busy flag, so the slave FSM consumes clean, clock-aligned events instead of sampling asynchronous pins.

Parameters:
SYNC_STAGES, 2, synchronizer flops per line (legal: >=2)
FILTER_CYCLES, 3, consecutive cycles a synchronized value must differ from the filtered value before the filtered value changes (legal: >=1)
IDLE_TIMEOUT, 0, cycles of SCL=1 and SDA=1 after which bus_busy self-clears; 0 disables

Ports:
clock  input  1  system clock, single clock domain
reset  input  1  synchronous, active-high reset
scl_in  input  1  raw SCL pin, asynchronous
sda_in  input  1  raw SDA pin, asynchronous
scl_filt  output  1  synchronized, filtered SCL level
sda_filt  output  1  synchronized, filtered SDA level
scl_rise  output  1  1-cycle strobe: scl_filt went 0->1
scl_fall  output  1  1-cycle strobe: scl_filt went 1->0
start_det  output  1  1-cycle strobe: START or repeated START
stop_det  output  1  1-cycle strobe: STOP
bus_busy  output  1  set by START, cleared by STOP, reset or idle timeout

Behaviour:
- Reset (synchronous, at a clock edge while reset=1):
  - all sync flops, scl_filt and sda_filt go to 1 (idle bus);
  - filter counters go to 0;
  - scl_rise, scl_fall, start_det, stop_det and bus_busy go to 0;
  - idle counter goes to 0.
- Reset mid-transfer: bus_busy drops and no STOP is reported. After reset, the first START is the first detected event.
- Synchronizer: plain shift chain, SYNC_STAGES deep. sync output = last stage.
- Glitch filter, per line, identical:
  - cnt increments each cycle in which sync != filt.
  - cnt clears to 0 in any cycle in which sync == filt.
  - When sync != filt and cnt == FILTER_CYCLES-1, filt takes the sync value at that edge and cnt clears.
  - Counter width = $clog2(FILTER_CYCLES+1). It never wraps.
- Latency: a pin change first sampled at edge 1 and held stable appears on filt at edge SYNC_STAGES+FILTER_CYCLES. Defaults: edge 5.
- Rejection: pulses shorter than FILTER_CYCLES synchronized cycles never reach filt.
- Strobes are registered and high exactly in the cycle in which filt holds its new value (set at the update edge, low at the next edge):
  - scl_rise / scl_fall follow the scl_filt transition.
  - start_det: sda_filt 1->0 at an edge where scl_filt is 1 before and after that edge.
  - stop_det: sda_filt 0->1 at an edge where scl_filt is 1 before and after that edge.
- Simultaneous update: if scl_filt and sda_filt change at the same edge, assert the SCL edge strobe only. No start_det or stop_det.
- start_det and stop_det are mutually exclusive by construction.
- bus_busy:
  - set at the edge after a start_det cycle;
  - cleared at the edge after a stop_det cycle;
  - a repeated START while busy keeps it 1.
- Idle timeout (IDLE_TIMEOUT>0):
  - idle counter increments while scl_filt=1 and sda_filt=1 and bus_busy=1, and clears otherwise;
  - on reaching IDLE_TIMEOUT it clears bus_busy and the counter, and asserts no strobe.
- No outputs depend combinationally on scl_in or sda_in.

Decomposition:
- Package i2c_pkg holds:
  - I2C_SYNC_STAGES_DEFAULT, I2C_FILTER_CYCLES_DEFAULT;
  - typedef i2c_event_t as a packed struct of scl_rise, scl_fall, start_det, stop_det, shared with the slave FSM.
- Sub-module i2c_glitch_filter (synchronizer + filter counter + filt register, parameters SYNC_STAGES and FILTER_CYCLES) is instantiated once for SCL and once for SDA.
- Edge, START/STOP, busy and timeout logic stay in i2c_line_conditioner.

Test Plan:
- Reset with pins at 1: all strobes and bus_busy 0, filt=1. Drop scl_in for 10 cycles (defaults) -> scl_fall high for exactly one cycle at edge 5; scl_filt=0 from edge 5.
- Glitch: scl_in 0 for 2 cycles then back to 1 (FILTER_CYCLES=3) -> scl_filt stays 1, no strobe. Repeat with 3 cycles -> one scl_fall.
- START then STOP, SCL held 1, with SDA 1->0 then later 0->1:
  - START -> start_det one cycle, bus_busy=1 the next cycle;
  - STOP -> stop_det one cycle, bus_busy=0 the next cycle.
- Both pins fall on the same clock edge -> scl_fall only, start_det=0, bus_busy unchanged.
- Repeated START while busy -> second start_det, bus_busy stays 1. Assert reset mid-transfer -> bus_busy=0 immediately after the reset edge, no stop_det.
- IDLE_TIMEOUT=20: START, then both lines held 1 -> bus_busy clears 20 cycles after the counter starts, with no stop_det.
